bcd_8: RTL and testbench
========================

// Module: bcd_8
// PURPOSE
//   Registered 8-bit unsigned binary to 3-digit BCD converter (0..255 -> 000..255).
//   Conversion core is an unrolled shift-and-add-3 (double-dabble) network.
//   One output register stage sits behind the network.
//   Feeds display/decimal-formatting logic that needs hundreds/tens/units digits.
// PARAMETERS
//   none -- input width fixed at 8 bits, output fixed at three 4-bit BCD digits.
// PORTS
//   clk        input   1  rising-edge clock; the only clock.
//   rst_n      input   1  reset: synchronous, active-low.
//   binary_in  input   8  unsigned binary value, 0..255.
//   hundreds   output  4  BCD hundreds digit, 0..2.
//   tens       output  4  BCD tens digit, 0..9.
//   units      output  4  BCD units digit, 0..9.
// BEHAVIOUR
//   - Reset: while rst_n=0 at a rising clk edge, hundreds/tens/units load 4'd0.
//     - Applies on the same edge even mid-stream.
//     - No asynchronous effect.
//   - Function: value N=binary_in gives
//     - hundreds = N/100
//     - tens     = (N%100)/10
//     - units    = N%10
//     - all as unsigned integer division.
//   - Latency: exactly 1 clk.
//     - binary_in sampled at edge k appears on outputs immediately after edge k.
//     - Outputs hold until the next edge.
//   - Throughput: one conversion per clock; a new value may be applied every cycle.
//   - No handshake, no valid flag: outputs always reflect the value sampled at the
//     previous edge, or 0 after reset.
//   - Core (combinational, fully unrolled, no iteration state):
//     - 20-bit scratch = {12'b0, binary_in}; 8 shift steps.
//     - Before each shift, any BCD nibble >= 5 gets +3.
//     - The final nibbles give units [11:8], tens [15:12], hundreds [19:16].
//   - Width rules:
//     - hundreds[3:2] always 0.
//     - No digit ever exceeds 9.
//     - No overflow possible.
//   - Boundaries:
//     - 0 -> 0/0/0
//     - 9/10, 99/100 and 199/200 carry digits correctly
//     - 255 -> 2/5/5
//   - Outputs are pure registers: no combinational path from binary_in to outputs.
// TESTING
//   - Reset: rst_n=0 for 2 edges with binary_in=8'd200 -> outputs 0/0/0.
//     After release, the next edge gives 2/0/0.
//   - Exhaustive sweep: binary_in 0..255, one value per clk.
//     - Check each result one edge later against N/100, (N%100)/10, N%10.
//     - Expect 256 passes, 0 fails.
//   - Carry boundaries:
//     - 9 -> 0/0/9, 10 -> 0/1/0
//     - 99 -> 0/9/9, 100 -> 1/0/0
//     - 199 -> 1/9/9, 200 -> 2/0/0
//     - 255 -> 2/5/5
//   - Back-to-back: 255 then 0 on consecutive edges -> outputs 2/5/5 then 0/0/0.
//     No intermediate glitch value is registered.
//   - Mid-stream reset: during a sweep, drop rst_n for 1 edge at N=137.
//     - That edge gives 0/0/0.
//     - The next edge with rst_n=1 resumes correct digits.

Source files
------------

// File: rtl/bcd_8.sv
// Registered 8-bit binary to 3-digit BCD converter using an unrolled double-dabble network.
// Latency 1 clk, one conversion per cycle, no handshake (always accepts a new value).
module bcd_8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] binary_in,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [19:0] scratch;
  logic [3:0]  hundreds_d, tens_d, units_d;
  logic [3:0]  hundreds_q, tens_q, units_q;

  // Each iteration is a separate slice of combinational logic once unrolled.
  always_comb begin
    scratch = {12'b0, binary_in};
    for (int i = 0; i < 8; i++) begin
      if (scratch[11:8] >= 4'd5) begin
        scratch[11:8] = scratch[11:8] + 4'd3;
      end
      if (scratch[15:12] >= 4'd5) begin
        scratch[15:12] = scratch[15:12] + 4'd3;
      end
      if (scratch[19:16] >= 4'd5) begin
        scratch[19:16] = scratch[19:16] + 4'd3;
      end
      scratch = {scratch[18:0], 1'b0};
    end
    units_d    = scratch[11:8];
    tens_d     = scratch[15:12];
    hundreds_d = scratch[19:16];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hundreds_q <= 4'd0;
      tens_q     <= 4'd0;
      units_q    <= 4'd0;
    end else begin
      hundreds_q <= hundreds_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
    end
  end

  assign hundreds = hundreds_q;
  assign tens     = tens_q;
  assign units    = units_q;

endmodule

// File: tb/tb_bcd_8.sv
// Directed bench for bcd_8: reset, exhaustive sweep, carry boundaries, back-to-back, mid-stream reset.
module tb_bcd_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] binary_in;
  logic [3:0] hundreds, tens, units;

  int passed = 0;
  int total  = 0;

  bcd_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .binary_in (binary_in),
    .hundreds  (hundreds),
    .tens      (tens),
    .units     (units)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then look at outputs just after the next rising edge.
  task automatic step(input logic [7:0] n, input logic r);
    @(negedge clk);
    binary_in = n;
    rst_n     = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] eh, input logic [3:0] et,
                       input logic [3:0] eu);
    total++;
    assert ({hundreds, tens, units} === {eh, et, eu}) passed++;
    else $error("FAIL %s: got %0d/%0d/%0d expected %0d/%0d/%0d",
                tag, hundreds, tens, units, eh, et, eu);
  endtask

  task automatic check_n(input string tag, input int n);
    check(tag, 4'(n / 100), 4'((n % 100) / 10), 4'(n % 10));
  endtask

  initial begin
    rst_n     = 1'b0;
    binary_in = 8'd200;

    // Reset held for two edges with a nonzero input
    step(8'd200, 1'b0); check("reset_edge1", 4'd0, 4'd0, 4'd0);
    step(8'd200, 1'b0); check("reset_edge2", 4'd0, 4'd0, 4'd0);
    step(8'd200, 1'b1); check("post_reset_200", 4'd2, 4'd0, 4'd0);

    // Exhaustive sweep, one value per clock
    for (int n = 0; n < 256; n++) begin
      step(8'(n), 1'b1);
      check_n($sformatf("sweep_%0d", n), n);
    end

    // Carry boundaries with hand-computed digits
    step(8'd0,   1'b1); check("b_0",   4'd0, 4'd0, 4'd0);
    step(8'd9,   1'b1); check("b_9",   4'd0, 4'd0, 4'd9);
    step(8'd10,  1'b1); check("b_10",  4'd0, 4'd1, 4'd0);
    step(8'd99,  1'b1); check("b_99",  4'd0, 4'd9, 4'd9);
    step(8'd100, 1'b1); check("b_100", 4'd1, 4'd0, 4'd0);
    step(8'd199, 1'b1); check("b_199", 4'd1, 4'd9, 4'd9);
    step(8'd200, 1'b1); check("b_200", 4'd2, 4'd0, 4'd0);
    step(8'd255, 1'b1); check("b_255", 4'd2, 4'd5, 4'd5);
    step(8'd137, 1'b1); check("b_137", 4'd1, 4'd3, 4'd7);
    step(8'd58,  1'b1); check("b_58",  4'd0, 4'd5, 4'd8);

    // Back-to-back extremes
    step(8'd255, 1'b1); check("b2b_255", 4'd2, 4'd5, 4'd5);
    step(8'd0,   1'b1); check("b2b_0",   4'd0, 4'd0, 4'd0);
    step(8'd255, 1'b1); check("b2b_255b", 4'd2, 4'd5, 4'd5);

    // Sweep with a one-edge reset at 137
    for (int n = 130; n < 146; n++) begin
      if (n == 137) begin
        step(8'(n), 1'b0);
        check("midrst_137", 4'd0, 4'd0, 4'd0);
      end else begin
        step(8'(n), 1'b1);
        check_n($sformatf("midsweep_%0d", n), n);
      end
    end
    step(8'd138, 1'b1); check("resume_138", 4'd1, 4'd3, 4'd8);

    // Hold: outputs keep the last sample while input is unchanged
    step(8'd138, 1'b1); check("hold_138", 4'd1, 4'd3, 4'd8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
